// File: rtl/legv8_iterative_multiplier.sv
// Multi-cycle shift-add unsigned multiplier for LEGv8 MUL/UMULH, writing back via the register file port.
// Define LEGV8_MUL_HIGH_EN to honour op_high (UMULH); otherwise the low half is always returned.
module legv8_iterative_multiplier #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              op_high,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  data,
  output logic [ADDR_W-1:0] write_reg_address,
  output logic              reg_write
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [2*WIDTH-1:0]  r_acc;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_dest;
  logic [WIDTH-1:0]    r_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]    w_result;
  logic                w_last;

  // Upper half plus optional multiplicand, carry kept so the shift brings it back into the MSB.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    w_last     = (r_state == S_BUSY) && (r_count == LAST_CNT);
  end

`ifdef LEGV8_MUL_HIGH_EN
  logic r_op_high;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_op_high <= 1'b0;
    else if (r_state == S_IDLE && start)
      r_op_high <= op_high;
  end

  always_comb w_result = r_op_high ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
`else
  logic w_unused_op_high;

  assign w_unused_op_high = op_high;
  always_comb w_result = w_acc_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_BUSY;
      S_BUSY:  if (r_count == LAST_CNT) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_dest    <= '0;
      r_data    <= '0;
      r_wr_addr <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mcand  <= operand_a;
        r_mplier <= operand_b;
        r_dest   <= dest_addr;
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc    <= w_acc_next;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CNT_W'(1);
      end
      // Result registers load on the final step so they hold through DONE and after.
      if (w_last) begin
        r_data    <= w_result;
        r_wr_addr <= r_dest;
      end
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE);
  assign reg_write         = (r_state == S_DONE) && (r_wr_addr != ZERO_IDX);
  assign data              = r_data;
  assign write_reg_address = r_wr_addr;

endmodule

// File: tb/tb_legv8_iterative_multiplier.sv
// Self-checking bench for legv8_iterative_multiplier: directed and random multiplies against a plain-arithmetic model.
module tb_legv8_iterative_multiplier;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic [ADDR_W-1:0] dest_addr;
  logic              op_high;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  data;
  logic [ADDR_W-1:0] write_reg_address;
  logic              reg_write;

  logic [WIDTH-1:0]  rf [32];
  int n_checks;
  int n_errors;

  legv8_iterative_multiplier #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (31)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .dest_addr         (dest_addr),
    .op_high           (op_high),
    .busy              (busy),
    .done              (done),
    .data              (data),
    .write_reg_address (write_reg_address),
    .reg_write         (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic hi);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`ifdef LEGV8_MUL_HIGH_EN
    return hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`else
    if (hi) return prod[WIDTH-1:0];
    return prod[WIDTH-1:0];
`endif
  endfunction

  // Issue one multiply, watch 70 cycles, optionally scramble inputs and re-pulse start mid-operation.
  task automatic do_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [ADDR_W-1:0] dest, input logic hi, input bit noise);
    logic [WIDTH-1:0] exp_data;
    int first_done;
    int busy_cnt;
    int pulses;
    int done_cnt;
    logic [WIDTH-1:0]  got_data;
    logic [ADDR_W-1:0] got_addr;
    exp_data   = model(a, b, hi);
    first_done = 0;
    busy_cnt   = 0;
    pulses     = 0;
    done_cnt   = 0;
    got_data   = '0;
    got_addr   = '0;
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    dest_addr = dest;
    op_high   = hi;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        got_data = data;
        got_addr = write_reg_address;
      end
      if (reg_write) begin
        pulses++;
        rf[write_reg_address] = data;
      end
      if (noise) begin
        operand_a = (k == 10) ? 64'd2 : {$urandom, $urandom};
        operand_b = (k == 10) ? 64'd2 : {$urandom, $urandom};
        dest_addr = ADDR_W'($urandom);
        op_high   = 1'($urandom);
        start     = (k == 10) || (k == 40);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_latency"}, 128'(first_done), 128'd65);
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd65);
    check({tag, "_done_pulses"}, 128'(done_cnt), 128'd1);
    check({tag, "_wr_pulses"}, 128'(pulses), (dest == 5'd31) ? 128'd0 : 128'd1);
    check({tag, "_data"}, 128'(got_data), 128'(exp_data));
    check({tag, "_addr"}, 128'(got_addr), 128'(dest));
    check({tag, "_idle_busy"}, 128'(busy), 128'd0);
    check({tag, "_hold_data"}, 128'(data), 128'(exp_data));
  endtask

  initial begin
    int rst_pulses;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    dest_addr = '0;
    op_high   = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_wr", 128'(reg_write), 128'd0);
    check("rst_data", 128'(data), 128'd0);
    check("rst_addr", 128'(write_reg_address), 128'd0);
    rst_n = 1'b1;

    do_mul("basic", 64'd43, 64'd3, 5'd9, 1'b0, 1'b0);
    check("rf9", 128'(rf[9]), 128'd129);
    do_mul("xzr", 64'd5, 64'd7, 5'd31, 1'b0, 1'b0);
    check("rf31", 128'(rf[31]), 128'd0);
    do_mul("ones_lo", '1, '1, 5'd3, 1'b0, 1'b0);
    check("ones_lo_val", 128'(rf[3]), 128'd1);
    do_mul("ones_hi", '1, '1, 5'd3, 1'b1, 1'b0);
`ifdef LEGV8_MUL_HIGH_EN
    check("ones_hi_val", 128'(rf[3]), 128'hFFFF_FFFF_FFFF_FFFE);
`else
    check("ones_hi_val", 128'(rf[3]), 128'd1);
`endif
    do_mul("zero", 64'd0, 64'd0, 5'd7, 1'b0, 1'b0);
    do_mul("noise", 64'd43, 64'd3, 5'd9, 1'b0, 1'b1);

    // Abort a multiply mid-flight with reset.
    @(negedge clk);
    operand_a = 64'd43;
    operand_b = 64'd3;
    dest_addr = 5'd12;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    rst_pulses = 0;
    for (int k = 1; k < 30; k++) begin
      if (reg_write) rst_pulses++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_data", 128'(data), 128'd0);
    check("abort_addr", 128'(write_reg_address), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (reg_write) rst_pulses++;
      @(negedge clk);
    end
    check("abort_no_write", 128'(rst_pulses), 128'd0);
    do_mul("after_rst", 64'd6, 64'd7, 5'd16, 1'b0, 1'b0);
    check("rf16", 128'(rf[16]), 128'd42);

    do_mul("pre4", 64'd2, 64'd3, 5'd4, 1'b0, 1'b0);
    check("rf4_pre", 128'(rf[4]), 128'd6);
    do_mul("chain_lo", 64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 1'b0, 1'b0);
    check("rf4_lo", 128'(rf[4]), 128'd0);
    do_mul("chain_hi", 64'h1_0000_0000, 64'h1_0000_0000, 5'd4, 1'b1, 1'b0);
`ifdef LEGV8_MUL_HIGH_EN
    check("rf4_hi", 128'(rf[4]), 128'd1);
`else
    check("rf4_hi", 128'(rf[4]), 128'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0]  ra;
      logic [WIDTH-1:0]  rb;
      logic [ADDR_W-1:0] rd;
      logic              rh;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rd = ADDR_W'($urandom_range(0, 30));
      rh = 1'($urandom);
      do_mul("rand", ra, rb, rd, rh, (i % 2) == 1);
      check("rand_rf", 128'(rf[rd]), 128'(model(ra, rb, rh)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
